// File: rtl/eip_pkg.sv
// Shared types and constants for the EIP redirect unit: FSM state encoding,
// default reset EIP and condition-flag bit positions.
package eip_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } eip_state_e;

    localparam logic [31:0] DEFAULT_RESET_EIP = 32'h0000_0000;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;

endpackage

// File: rtl/eip_cond_eval.sv
// Combinational evaluation of a writeback control transfer: checks the masked
// flag condition and picks the resulting target, truncating to 16 bits if asked.
module eip_cond_eval #(
    parameter int AW    = 32,
    parameter int NFLAG = 2
) (
    input  logic [NFLAG-1:0] cond_mask_i,
    input  logic [NFLAG-1:0] flags_i,
    input  logic [NFLAG-1:0] expected_i,
    input  logic [AW-1:0]    tgt_a_i,
    input  logic [AW-1:0]    tgt_b_i,
    input  logic             tgt_sel_i,
    input  logic [AW-1:0]    eip_next_i,
    input  logic             size16_i,
    output logic             cond_met_o,
    output logic [AW-1:0]    tgt_o
);

    // Unmasked flags never block the condition, so an all-zero mask is met.
    always_comb begin
        cond_met_o = 1'b1;
        for (int i = 0; i < NFLAG; i++) begin
            cond_met_o = cond_met_o & (~cond_mask_i[i] | (flags_i[i] ~^ expected_i[i]));
        end
    end

    always_comb begin
        tgt_o = cond_met_o ? (tgt_sel_i ? tgt_b_i : tgt_a_i) : eip_next_i;
        if (size16_i) begin
            for (int i = 16; i < AW; i++) begin
                tgt_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/eip_redirect_unit.sv
// Architectural EIP register with writeback override and fetch redirect FSM.
// Optional feature: define EIP_MISPRED_CNT_EN to add the mispred_cnt counter.
module eip_redirect_unit
    import eip_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            NFLAG      = 2,
    parameter int            SQUASH_CYC = 2,
    parameter logic [AW-1:0] RESET_EIP  = AW'(DEFAULT_RESET_EIP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic             de_stall,
    input  logic [AW-1:0]    de_eip_next,
    input  logic             wb_valid,
    input  logic             wb_eip_change,
    input  logic [AW-1:0]    wb_tgt_a,
    input  logic [AW-1:0]    wb_tgt_b,
    input  logic             wb_tgt_sel,
    input  logic [AW-1:0]    wb_eip_next,
    input  logic [NFLAG-1:0] wb_cond_mask,
    input  logic [NFLAG-1:0] wb_flags,
    input  logic [NFLAG-1:0] wb_expected,
    input  logic             wb_size16,
    input  logic             fe_ready,
    output logic [AW-1:0]    eip,
    output logic [1:0]       ld_eip,
    output logic             fe_redirect_valid,
    output logic [AW-1:0]    fe_redirect_eip,
    output logic             squash,
    output logic             busy
`ifdef EIP_MISPRED_CNT_EN
    ,
    output logic [31:0]      mispred_cnt
`endif
);

    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYC - 1);

    eip_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] eip_q, eip_d;
    logic [AW-1:0] redir_q, redir_d;
    logic          cond_met;
    logic [AW-1:0] tgt;
    logic          wb_ld;
    logic          de_ld;

    eip_cond_eval #(
        .AW    (AW),
        .NFLAG (NFLAG)
    ) u_cond_eval (
        .cond_mask_i (wb_cond_mask),
        .flags_i     (wb_flags),
        .expected_i  (wb_expected),
        .tgt_a_i     (wb_tgt_a),
        .tgt_b_i     (wb_tgt_b),
        .tgt_sel_i   (wb_tgt_sel),
        .eip_next_i  (wb_eip_next),
        .size16_i    (wb_size16),
        .cond_met_o  (cond_met),
        .tgt_o       (tgt)
    );

    // Outside RUN every incoming instruction is wrong-path, so loads are gated.
    assign wb_ld = wb_valid & wb_eip_change & (state_q == RUN);
    assign de_ld = de_valid & ~de_stall & (state_q == RUN) & ~wb_ld;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eip_d   = eip_q;
        redir_d = redir_q;

        case (state_q)
            RUN: begin
                if (wb_ld) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (fe_ready) begin
                    if (SQUASH_CYC == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = SQUASH;
                        cnt_d   = SQ_LOAD;
                    end
                end
            end
            SQUASH: begin
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (wb_ld) begin
            eip_d   = tgt;
            redir_d = tgt;
        end else if (de_ld) begin
            eip_d = de_eip_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            eip_q   <= RESET_EIP;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eip_q   <= eip_d;
            redir_q <= redir_d;
        end
    end

    assign eip               = eip_q;
    assign ld_eip            = {wb_ld, de_ld};
    assign fe_redirect_valid = (state_q == HOLD);
    assign fe_redirect_eip   = redir_q;
    assign squash            = (state_q != RUN);
    assign busy              = (state_q != RUN);

`ifdef EIP_MISPRED_CNT_EN
    logic [31:0] mispred_q;

    // A mispredict is a conditional transfer (non-empty mask) that fell through.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_q <= 32'd0;
        end else if (wb_ld && (|wb_cond_mask) && !cond_met && (mispred_q != 32'hFFFF_FFFF)) begin
            mispred_q <= mispred_q + 32'd1;
        end
    end

    assign mispred_cnt = mispred_q;
`else
    logic unused_cond_met;
    assign unused_cond_met = cond_met;
`endif

endmodule

// File: tb/tb_eip_redirect_unit.sv
// Self-checking bench for eip_redirect_unit: vector table for single transfers
// plus sequences for squash timing, stalled handshake and reset during HOLD.
module tb_eip_redirect_unit;

    logic        clk;
    logic        rst;
    logic        de_valid;
    logic        de_stall;
    logic [31:0] de_eip_next;
    logic        wb_valid;
    logic        wb_eip_change;
    logic [31:0] wb_tgt_a;
    logic [31:0] wb_tgt_b;
    logic        wb_tgt_sel;
    logic [31:0] wb_eip_next;
    logic [1:0]  wb_cond_mask;
    logic [1:0]  wb_flags;
    logic [1:0]  wb_expected;
    logic        wb_size16;
    logic        fe_ready;
    logic [31:0] eip;
    logic [1:0]  ld_eip;
    logic        fe_redirect_valid;
    logic [31:0] fe_redirect_eip;
    logic        squash;
    logic        busy;
`ifdef EIP_MISPRED_CNT_EN
    logic [31:0] mispred_cnt;
`endif

    int checks;
    int failures;

    eip_redirect_unit #(
        .AW         (32),
        .NFLAG      (2),
        .SQUASH_CYC (2),
        .RESET_EIP  (32'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .de_valid          (de_valid),
        .de_stall          (de_stall),
        .de_eip_next       (de_eip_next),
        .wb_valid          (wb_valid),
        .wb_eip_change     (wb_eip_change),
        .wb_tgt_a          (wb_tgt_a),
        .wb_tgt_b          (wb_tgt_b),
        .wb_tgt_sel        (wb_tgt_sel),
        .wb_eip_next       (wb_eip_next),
        .wb_cond_mask      (wb_cond_mask),
        .wb_flags          (wb_flags),
        .wb_expected       (wb_expected),
        .wb_size16         (wb_size16),
        .fe_ready          (fe_ready),
        .eip               (eip),
        .ld_eip            (ld_eip),
        .fe_redirect_valid (fe_redirect_valid),
        .fe_redirect_eip   (fe_redirect_eip),
        .squash            (squash),
        .busy              (busy)
`ifdef EIP_MISPRED_CNT_EN
        ,
        .mispred_cnt       (mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        deValid;
        logic        deStall;
        logic [31:0] deNext;
        logic        wbValid;
        logic        wbChange;
        logic [31:0] tgtA;
        logic [31:0] tgtB;
        logic        sel;
        logic [31:0] wbNext;
        logic [1:0]  mask;
        logic [1:0]  flags;
        logic [1:0]  expected;
        logic        size16;
        logic [1:0]  ldExp;
        logic [31:0] eipExp;
    } tbVec_t;

    tbVec_t vecs[12];

    // Drive one record's inputs; fe_ready is handled by the callers.
    task automatic applyStimulus(input tbVec_t v);
        de_valid      = v.deValid;
        de_stall      = v.deStall;
        de_eip_next   = v.deNext;
        wb_valid      = v.wbValid;
        wb_eip_change = v.wbChange;
        wb_tgt_a      = v.tgtA;
        wb_tgt_b      = v.tgtB;
        wb_tgt_sel    = v.sel;
        wb_eip_next   = v.wbNext;
        wb_cond_mask  = v.mask;
        wb_flags      = v.flags;
        wb_expected   = v.expected;
        wb_size16     = v.size16;
    endtask

    task automatic clearInputs();
        tbVec_t idle;
        idle = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0};
        applyStimulus(idle);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bounded wait for the FSM to get back to RUN; sampled just after negedge.
    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int sqCount;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        fe_ready = 1'b0;
        clearInputs();

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 32'h0000_0100};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0000_0100};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0000_0100};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 1'b0, 32'h0000_0104,
                     2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 32'h0000_2000};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 1'b0, 32'h0000_0104,
                     2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 32'h0000_0104};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1111, 32'hABCD_1234, 1'b1, 32'h0000_0108,
                     2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000, 1'b0, 32'h0000_0110,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 32'h0000_5000};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_6500, 32'h0000_7000, 1'b1, 32'h0000_0114,
                     2'b11, 2'b01, 2'b01, 1'b0, 2'b10, 32'h0000_7000};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_6500, 32'h0000_7000, 1'b1, 32'h0000_8000,
                     2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 32'h0000_8000};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_9999, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 32'h0000_0400};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_9999, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0000_0400};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 32'h0000_0500};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_eip",    eip,                       32'h0);
        checkOutput("rst_ld",     {30'd0, ld_eip},           32'h0);
        checkOutput("rst_frv",    {31'd0, fe_redirect_valid}, 32'h0);
        checkOutput("rst_fre",    fe_redirect_eip,           32'h0);
        checkOutput("rst_squash", {31'd0, squash},           32'h0);
        checkOutput("rst_busy",   {31'd0, busy},             32'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ld", i), {30'd0, ld_eip}, {30'd0, vecs[i].ldExp});
            @(negedge clk);
            clearInputs();
            #1;
            checkOutput($sformatf("vec%0d_eip", i), eip, vecs[i].eipExp);
            if (vecs[i].ldExp[1]) begin
                checkOutput($sformatf("vec%0d_frv", i), {31'd0, fe_redirect_valid}, 32'd1);
                checkOutput($sformatf("vec%0d_fre", i), fe_redirect_eip, vecs[i].eipExp);
                fe_ready = 1'b1;
                waitIdle($sformatf("vec%0d_idle", i));
                fe_ready = 1'b0;
            end
        end

`ifdef EIP_MISPRED_CNT_EN
        checkOutput("mispred_cnt", mispred_cnt, 32'd2);
`endif

        // Squash window: HOLD accepted immediately, then SQUASH_CYC cycles.
        @(negedge clk);
        wb_valid      = 1'b1;
        wb_eip_change = 1'b1;
        wb_tgt_a      = 32'h0000_A000;
        @(negedge clk);
        clearInputs();
        fe_ready = 1'b1;
        sqCount  = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!squash) break;
            sqCount++;
            @(negedge clk);
        end
        fe_ready = 1'b0;
        checkOutput("sq_count", sqCount, 32'd3);
        checkOutput("sq_busy",  {31'd0, busy}, 32'd0);
        checkOutput("sq_eip",   eip, 32'h0000_A000);

        // Simultaneous wb/de, then wrong-path traffic while fetch stalls.
        @(negedge clk);
        wb_valid      = 1'b1;
        wb_eip_change = 1'b1;
        wb_tgt_a      = 32'h0000_9000;
        de_valid      = 1'b1;
        de_eip_next   = 32'h0000_0600;
        #1;
        checkOutput("sim_ld", {30'd0, ld_eip}, 32'd2);
        @(negedge clk);
        wb_tgt_a    = 32'h0000_DEAD;
        de_eip_next = 32'h0000_0700;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("hold%0d_ld", i),  {30'd0, ld_eip}, 32'd0);
            checkOutput($sformatf("hold%0d_eip", i), eip, 32'h0000_9000);
            checkOutput($sformatf("hold%0d_fre", i), fe_redirect_eip, 32'h0000_9000);
            checkOutput($sformatf("hold%0d_frv", i), {31'd0, fe_redirect_valid}, 32'd1);
            @(negedge clk);
        end
        fe_ready = 1'b1;
        waitIdle("hold_idle");
        fe_ready = 1'b0;
        clearInputs();
        checkOutput("hold_eip_after", eip, 32'h0000_9000);

        // Reset while a redirect is pending.
        @(negedge clk);
        wb_valid      = 1'b1;
        wb_eip_change = 1'b1;
        wb_tgt_a      = 32'h0000_B000;
        @(negedge clk);
        clearInputs();
        #1;
        checkOutput("rh_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rh_eip",    eip, 32'h0);
        checkOutput("rh_frv",    {31'd0, fe_redirect_valid}, 32'd0);
        checkOutput("rh_busy",   {31'd0, busy}, 32'd0);
        checkOutput("rh_squash", {31'd0, squash}, 32'd0);
        checkOutput("rh_fre",    fe_redirect_eip, 32'h0);
`ifdef EIP_MISPRED_CNT_EN
        checkOutput("rh_mispred", mispred_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eip_redirect_unit.md
# eip_redirect_unit

Parametrised successor to the writeback-stage EIP register. Holds the architectural EIP, advances it from decode, and overrides it on writeback control transfers evaluated against an N-flag condition mask. Sequences the resulting fetch redirect with a valid/ready handshake and a programmable squash window. Sits between decode, writeback and the fetch unit.

## Interface

Parameters:
- AW, 32, EIP width.
- NFLAG, 2, number of condition flags evaluated; bit 0 = CF, bit 1 = ZF.
- SQUASH_CYC, 2, cycles squash stays high after the redirect handshake; 0..15.
- RESET_EIP, 0, EIP value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- de_valid  in  1  decode holds a valid instruction.
- de_stall  in  1  OR of fetch stall, branch stall and I-cache exception; blocks decode advance.
- de_eip_next  in  AW  sequential EIP from decode.
- wb_valid  in  1  writeback instruction valid.
- wb_eip_change  in  1  instruction writes EIP.
- wb_tgt_a, wb_tgt_b  in  AW  candidate targets.
- wb_tgt_sel  in  1  0 selects wb_tgt_a, 1 selects wb_tgt_b.
- wb_eip_next  in  AW  fall-through EIP.
- wb_cond_mask  in  NFLAG  flags participating in the condition.
- wb_flags, wb_expected  in  NFLAG  resolved and expected flag values.
- wb_size16  in  1  16-bit operand size; target is zero-extended from bit 15.
- fe_ready  in  1  fetch accepts the redirect.
- eip  out  AW  architectural EIP.
- ld_eip  out  2  {wb load, de load} strobes for the current cycle.
- fe_redirect_valid  out  1  redirect request to fetch.
- fe_redirect_eip  out  AW  redirect target; stable while valid.
- squash  out  1  flush younger pipeline state.
- busy  out  1  state != RUN.

## Operation

- cond_met = AND over i of (~wb_cond_mask[i] | (wb_flags[i] ~^ wb_expected[i])). An all-zero mask is met.
- tgt = cond_met ? (wb_tgt_sel ? wb_tgt_b : wb_tgt_a) : wb_eip_next. If wb_size16, bits AW-1:16 are forced to 0.
- wb_ld = wb_valid & wb_eip_change & (state == RUN).
- de_ld = de_valid & ~de_stall & (state == RUN) & ~wb_ld.
- On wb_ld: eip <= tgt, fe_redirect_eip <= tgt, state goes to HOLD.
- On de_ld: eip <= de_eip_next.
- FSM states:
  - RUN: normal operation; wb_ld moves to HOLD.
  - HOLD: fe_redirect_valid = 1 and squash = 1. When fe_ready = 1, go to SQUASH, or to RUN if SQUASH_CYC = 0.
  - SQUASH: squash = 1; a counter loads SQUASH_CYC-1 and decrements; go to RUN when it reaches 0.
- In HOLD and SQUASH, all wb_valid and de_valid inputs are wrong-path and are ignored. eip does not change.
- A simultaneous wb and de event in RUN: wb wins, and ld_eip = 2'b10.

## Timing

- Reset values: eip = RESET_EIP, state RUN, ld_eip = 0, fe_redirect_valid = 0, fe_redirect_eip = 0, squash = 0, busy = 0, counter = 0.
- ld_eip is combinational, in the same cycle as the event. eip updates at the next clock edge (1-cycle latency).
- fe_redirect_valid rises the cycle after wb_ld. It stays high with fe_redirect_eip stable until the cycle where fe_ready = 1 (inclusive).
- fe_ready may be high on the first valid cycle; the handshake then takes 1 cycle.
- Redirect-to-RUN time = 1 + handshake wait + SQUASH_CYC cycles.
- rst in any state returns all outputs to reset values at the next edge and drops any pending redirect.

## Configuration

- EIP_MISPRED_CNT_EN defined:
  - Adds output mispred_cnt [31:0].
  - The counter increments on each wb_ld where wb_cond_mask != 0 and cond_met = 0.
  - It saturates at 32'hFFFF_FFFF and clears on rst.
- EIP_MISPRED_CNT_EN undefined: the port and counter are absent.

## Structure

- Package eip_pkg holds:
  - the state enum (RUN, HOLD, SQUASH);
  - a default RESET_EIP constant;
  - the flag-index constants (CF = 0, ZF = 1).
- One sub-module, eip_cond_eval: combinational, parametrised by NFLAG and AW, and produces cond_met and tgt.

## Test plan

- Reset, then de_valid = 1, de_stall = 0, de_eip_next = 32'h100 → ld_eip = 01; eip = 32'h100 the next cycle.
- wb jcc: mask = 2'b10, flags = 2'b10, expected = 2'b10, tgt_a = 32'h2000, fe_ready = 1 in the 2nd cycle, SQUASH_CYC = 2 → eip = 32'h2000, redirect handshake completes, squash is high for 3 cycles, then RUN.
- Same as above but flags = 2'b00 (condition not met), wb_eip_next = 32'h104 → eip = 32'h104; redirect to 32'h104; with EIP_MISPRED_CNT_EN, mispred_cnt = 1.
- wb_size16 = 1, tgt_b = 32'hABCD_1234, sel = 1 → eip = 32'h0000_1234.
- Simultaneous wb_ld and de_ld, then de_valid held during HOLD with fe_ready = 0 for 5 cycles → ld_eip = 10; eip is unchanged through HOLD; fe_redirect_eip is stable.
- rst asserted during HOLD → next cycle eip = RESET_EIP, fe_redirect_valid = 0, busy = 0.
